// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Two-master arbiter in front of a single-ported DRAM driver.
//   m0 is the CPU data port, m1 the debug/loader port. Writes complete in
//   the grant cycle. A read takes the grant cycle plus one RD cycle, in which
//   the driver returns formatted data and the arbiter steers it to the owner.
//
//   Arbitration (default build): m0 has fixed priority. m1 is forced through
//   after it has lost MAX_WAIT consecutive arbitration cycles.
//   Arbitration with DRAM_ARB_RR_EN defined: round-robin between the two
//   masters using a 1-bit pointer. The wait counter logic is not built.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   m0_req/we/addr/wdata/mask        CPU request and payload
//   m0_gnt, m0_rvalid, m0_rdata      CPU grant and read return
//   m1_*                             same set of signals for the loader port
//   perip_addr/wdata/mask, dram_wen  request forwarded to the DRAM driver
//   perip_rdata                      formatted read data from the driver
//   state_dbg                        1 while the FSM is in RD
//
// Handshake: a master holds req and payload stable until it sees gnt. The
// payload is sampled only in the grant cycle. For a read, rvalid follows gnt
// by exactly one cycle.
module dram_arbiter #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [17:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [1:0]  m0_mask,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [17:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [1:0]  m1_mask,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic [17:0] perip_addr,
   output logic [31:0] perip_wdata,
   output logic [1:0]  perip_mask,
   output logic        dram_wen,
   input  logic [31:0] perip_rdata,
   output logic        state_dbg
);

   typedef enum logic {IDLE = 1'b0, RD = 1'b1} state_t;

   state_t      state, next_state;
   logic [17:0] lat_addr;
   logic [1:0]  lat_mask;
   logic        lat_owner;   // 0 = m0, 1 = m1
   logic        pick_m1;     // winner select when at least one req is up
   logic        win_m0, win_m1;

`ifdef DRAM_ARB_RR_EN
   logic        rr_ptr;      // master that wins the next tie
`else
   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
   logic [7:0]  wait_cnt;
`endif

   assign state_dbg = (state == RD);

   always_comb begin
      next_state  = state;
      pick_m1     = 1'b0;
      win_m0      = 1'b0;
      win_m1      = 1'b0;
      m0_gnt      = 1'b0;
      m1_gnt      = 1'b0;
      m0_rvalid   = 1'b0;
      m1_rvalid   = 1'b0;
      m0_rdata    = 32'h0;
      m1_rdata    = 32'h0;
      perip_addr  = 18'h0;
      perip_wdata = 32'h0;
      perip_mask  = 2'b00;
      dram_wen    = 1'b0;

      if (state == IDLE) begin
         if (m0_req && m1_req) begin
`ifdef DRAM_ARB_RR_EN
            pick_m1 = rr_ptr;
`else
            pick_m1 = (wait_cnt == MAX_WAIT_C);
`endif
         end else begin
            pick_m1 = m1_req;
         end
         win_m0 = (m0_req || m1_req) && !pick_m1;
         win_m1 = (m0_req || m1_req) && pick_m1;
         m0_gnt = win_m0;
         m1_gnt = win_m1;
         if (win_m1) begin
            perip_addr  = m1_addr;
            perip_wdata = m1_wdata;
            perip_mask  = m1_mask;
            dram_wen    = m1_we;
            if (!m1_we) next_state = RD;
         end else if (win_m0) begin
            perip_addr  = m0_addr;
            perip_wdata = m0_wdata;
            perip_mask  = m0_mask;
            dram_wen    = m0_we;
            if (!m0_we) next_state = RD;
         end
      end else begin
         // Keep the read address on the bus: the driver formats its data
         // with the address and mask it sees in this cycle.
         perip_addr = lat_addr;
         perip_mask = lat_mask;
         if (lat_owner) begin
            m1_rvalid = 1'b1;
            m1_rdata  = perip_rdata;
         end else begin
            m0_rvalid = 1'b1;
            m0_rdata  = perip_rdata;
         end
         next_state = IDLE;
      end

      // Outputs are forced low while reset is held, even though the
      // grant path is combinational from the request inputs.
      if (!rst_n) begin
         win_m0      = 1'b0;
         win_m1      = 1'b0;
         m0_gnt      = 1'b0;
         m1_gnt      = 1'b0;
         m0_rvalid   = 1'b0;
         m1_rvalid   = 1'b0;
         m0_rdata    = 32'h0;
         m1_rdata    = 32'h0;
         perip_addr  = 18'h0;
         perip_wdata = 32'h0;
         perip_mask  = 2'b00;
         dram_wen    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lat_addr  <= 18'h0;
         lat_mask  <= 2'b00;
         lat_owner <= 1'b0;
      end else begin
         state <= next_state;
         if (state == IDLE && (win_m0 || win_m1)) begin
            lat_addr  <= perip_addr;
            lat_mask  <= perip_mask;
            lat_owner <= win_m1;
         end
      end
   end

`ifdef DRAM_ARB_RR_EN
   // Pointer only moves on contested grants; it then points at the loser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= 1'b0;
      end else if (state == IDLE && m0_req && m1_req) begin
         rr_ptr <= ~win_m1;
      end
   end
`else
   // Counts consecutive cycles in which m1 asked but m0 got the grant.
   // Holds through RD, since no arbitration happens there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 8'h0;
      end else if (!m1_req || win_m1) begin
         wait_cnt <= 8'h0;
      end else if (win_m0 && wait_cnt != MAX_WAIT_C) begin
         wait_cnt <= wait_cnt + 8'h1;
      end
   end
`endif

endmodule
